// File: rtl/x_play_pkg.sv
// Shared types and default sizing for the IceDAC sample loader / playback sequencer.
// Memory depth drives the default address width so the two cannot disagree.
package x_play_pkg;

  localparam int MEM_DEPTH    = 2048;
  localparam int X_ADDR_W     = $clog2(MEM_DEPTH);
  localparam int X_DATA_W     = 6;
  localparam int X_READ_LAT   = 3;
  localparam int X_DIV_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/x_play_tick.sv
// Playback rate divider: reloads with the latched period and pulses a tick
// every period+1 cycles while running.
module x_play_tick #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_start,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt    <= '0;
      period <= '0;
    end else if (i_start) begin
      cnt    <= i_div;
      period <= i_div;
    end else if (i_run) begin
      cnt <= (cnt == '0) ? period : cnt - 1'b1;
    end
  end

  assign o_tick = i_run && (cnt == '0);

endmodule

// File: rtl/x_play.sv
// Sample loader and cyclic playback sequencer; sole master of the sample memory.
// Loads a waveform from a valid/ready stream, then replays it at a divided rate.
module x_play
  import x_play_pkg::*;
#(
  parameter int ADDR_W   = X_ADDR_W,
  parameter int DATA_W   = X_DATA_W,
  parameter int READ_LAT = X_READ_LAT,
  parameter int DIV_W    = X_DIV_W
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  input  logic              i_play,
  input  logic [DIV_W-1:0]  i_div,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_valid,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_playing
);

  state_t              state;
  state_t              next_state;
  logic                loaded;
  logic [READ_LAT-1:0] rd_pipe;
  logic                accept;
  logic                last_beat;
  logic                issue;
  logic                start_play;
  logic                tick;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;

  assign accept = i_load_valid && o_load_ready;

  // o_mem_addr doubles as the write pointer during LOAD and the read pointer in PLAY.
  assign wr_addr   = (state == ST_LOAD) ? o_mem_addr + 1'b1 : '0;
  assign last_beat = i_load_last || (&wr_addr);
  assign rd_addr   = (start_play || (o_mem_addr == o_len)) ? '0 : o_mem_addr + 1'b1;

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    next_state = state;
    start_play = 1'b0;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        // A load beat wins over a play request; a single-beat waveform
        // with last set completes immediately.
        if (accept) begin
          next_state = last_beat ? ST_IDLE : ST_LOAD;
        end else if (i_play && loaded) begin
          next_state = ST_PLAY;
          start_play = 1'b1;
          issue      = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept && last_beat) next_state = ST_IDLE;
      end
      ST_PLAY: begin
        if (!i_play)   next_state = ST_IDLE;
        else if (tick) issue      = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= ST_IDLE;
      loaded       <= 1'b0;
      o_load_ready <= 1'b0;
      o_playing    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_we     <= 1'b0;
      o_mem_wdata  <= '0;
      o_len        <= '0;
    end else begin
      state        <= next_state;
      o_load_ready <= (next_state != ST_PLAY);
      o_playing    <= (next_state == ST_PLAY);
      o_mem_we     <= accept;
      if (accept) begin
        o_mem_addr  <= wr_addr;
        o_mem_wdata <= i_load_data;
        loaded      <= last_beat;
        if (last_beat) o_len <= wr_addr;
      end else if (issue) begin
        o_mem_addr <= rd_addr;
      end
    end
  end

  // NOTE: the read pipe is a handful of flops, not a memory, so it is reset;
  // that is what drops in-flight reads on an asynchronous reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rd_pipe        <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
    end else begin
      rd_pipe[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      o_sample_valid <= rd_pipe[READ_LAT-1];
      if (rd_pipe[READ_LAT-1]) o_sample <= i_mem_rdata;
    end
  end

  x_play_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_start(start_play),
    .i_run  (state == ST_PLAY),
    .i_div  (i_div),
    .o_tick (tick)
  );

endmodule
